// File: rtl/alu_op_sequencer_if.sv
// Command, ALU pin and response signals of the ALU op sequencer.
// slave is the sequencer's view; master is the view of the logic around it
// (command source, ALU and result sink together).
interface alu_op_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_cmd;
    logic             alu_oe;
    logic [63:0]      alu_d;
    logic             res_valid;
    logic             res_ready;
    logic [63:0]      res_data;
    logic             res_div0;
    logic [CNT_W-1:0] op_count;
    logic             busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_d, res_ready,
        output cmd_ready, alu_a, alu_b, alu_cmd, alu_oe,
               res_valid, res_data, res_div0, op_count, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_d, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_cmd, alu_oe,
               res_valid, res_data, res_div0, op_count, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue/capture stage for the 32-bit combinational ALU. Registers one
// command onto the ALU pins, enables the ALU result bus for SETTLE_CYC
// cycles, captures the 64-bit result on the last enabled edge and holds it
// until the downstream handshake. SETTLE_CYC must lie in 1..15.
module alu_op_sequencer #(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t           state, state_nxt;
    logic [3:0]       settle_cnt;
    logic             div0_pend;
    logic [31:0]      a_q, b_q;
    logic [3:0]       op_q;
    logic [63:0]      data_q;
    logic             div0_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cmd_ready;
    logic             accept;
    logic             res_hs;

    assign accept = bus.cmd_valid & cmd_ready;
    assign res_hs = (state == RESP) & bus.res_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and command-side ready. A handshake in RESP frees the
    // capture register, so a waiting command may be taken on that same edge.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) state_nxt = DRIVE;
            end
            DRIVE: begin
                if (settle_cnt == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                cmd_ready = bus.res_ready;
                if (bus.res_ready) state_nxt = bus.cmd_valid ? DRIVE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, settle countdown, result capture and handoff counter.
    // alu_d is only sampled in DRIVE, i.e. while alu_oe is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            div0_pend  <= 1'b0;
            settle_cnt <= '0;
            data_q     <= '0;
            div0_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (accept) begin
                a_q        <= bus.cmd_a;
                b_q        <= bus.cmd_b;
                op_q       <= bus.cmd_op;
                div0_pend  <= (bus.cmd_op == 4'b0101) && (bus.cmd_b == 32'd0);
                settle_cnt <= SETTLE_LOAD;
            end else if (state == DRIVE) begin
                if (settle_cnt == 4'd0) begin
                    data_q <= bus.alu_d;
                    div0_q <= div0_pend;
                end else begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
            end
            if (res_hs) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_cmd   = op_q;
    assign bus.alu_oe    = (state == DRIVE);
    assign bus.res_valid = (state == RESP);
    assign bus.res_data  = data_q;
    assign bus.res_div0  = div0_q;
    assign bus.op_count  = cnt_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (SETTLE_CYC=1/CNT_W=16 and
// SETTLE_CYC=3/CNT_W=4), a behavioural ALU on each result bus, a vector
// table, backpressure / reset / counter-wrap sequences and random ops.
module tb_alu_op_sequencer;
    localparam logic [63:0] FLOAT = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.CNT_W(16)) if0 ();
    alu_op_sequencer_if #(.CNT_W(4))  if1 ();

    alu_op_sequencer #(.SETTLE_CYC(1), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    alu_op_sequencer #(.SETTLE_CYC(3), .CNT_W(4))  u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    // ALU model; opcode map: 0 ADD, 1 SUB, 2 MUL, 5 DIV, 6 XOR, else BUF A.
    function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return {32'd0, a} + {32'd0, b};
            4'd1:    return {32'd0, a} - {32'd0, b};
            4'd2:    return 64'(a) * 64'(b);
            4'd5:    return (b == 0) ? 64'd0 : {32'd0, a / b};
            4'd6:    return {32'd0, a ^ b};
            default: return {32'd0, a};
        endcase
    endfunction

    // Floating bus is modelled as a poison pattern so a stray sample shows up.
    assign if0.alu_d = if0.alu_oe ? alu_f(if0.alu_cmd, if0.alu_a, if0.alu_b) : FLOAT;
    assign if1.alu_d = if1.alu_oe ? alu_f(if1.alu_cmd, if1.alu_a, if1.alu_b) : FLOAT;

    logic        cv[2], rr[2];
    logic [3:0]  cop[2];
    logic [31:0] ca[2], cb[2];
    logic        crdy[2], oe[2], rv[2], dz[2], bsy[2];
    logic [63:0] rd[2];
    logic [31:0] aa[2];
    logic [15:0] oc[2];

    assign if0.cmd_valid = cv[0];  assign if1.cmd_valid = cv[1];
    assign if0.cmd_op    = cop[0]; assign if1.cmd_op    = cop[1];
    assign if0.cmd_a     = ca[0];  assign if1.cmd_a     = ca[1];
    assign if0.cmd_b     = cb[0];  assign if1.cmd_b     = cb[1];
    assign if0.res_ready = rr[0];  assign if1.res_ready = rr[1];
    assign crdy[0] = if0.cmd_ready; assign crdy[1] = if1.cmd_ready;
    assign oe[0]   = if0.alu_oe;    assign oe[1]   = if1.alu_oe;
    assign rv[0]   = if0.res_valid; assign rv[1]   = if1.res_valid;
    assign dz[0]   = if0.res_div0;  assign dz[1]   = if1.res_div0;
    assign bsy[0]  = if0.busy;      assign bsy[1]  = if1.busy;
    assign rd[0]   = if0.res_data;  assign rd[1]   = if1.res_data;
    assign aa[0]   = if0.alu_a;     assign aa[1]   = if1.alu_a;
    assign oc[0]   = if0.op_count;  assign oc[1]   = {12'd0, if1.op_count};

    int          settle[2];
    logic [15:0] mask[2];
    logic [15:0] exp_cnt[2];
    int          checks = 0;
    int          fails = 0;

    typedef struct {
        int          k;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [63:0] d;
        logic        dz;
    } vec_t;
    vec_t tv[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Wait (bounded) for res_valid, counting enabled cycles on the way.
    task automatic wait_res(input int k, output int oe_cnt);
        int cyc = 0;
        oe_cnt = 0;
        @(negedge clk);
        while (!rv[k] && cyc < 40) begin
            if (oe[k]) oe_cnt++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic handshake(input int k, input string nm);
        rr[k] = 1'b1;
        @(posedge clk); #1;
        rr[k] = 1'b0;
        exp_cnt[k] = (exp_cnt[k] + 16'd1) & mask[k];
        @(negedge clk);
        chk({nm, " op_count"}, 64'(oc[k]), 64'(exp_cnt[k]));
        chk({nm, " res_valid drop"}, 64'(rv[k]), 64'd0);
    endtask

    task automatic do_op(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] ed, input logic edz, input string nm);
        int oe_cnt;
        @(negedge clk);
        chk({nm, " cmd_ready idle"}, 64'(crdy[k]), 64'd1);
        cv[k] = 1'b1; cop[k] = op; ca[k] = a; cb[k] = b; rr[k] = 1'b0;
        @(posedge clk); #1;
        cv[k] = 1'b0; cop[k] = 4'($urandom); ca[k] = $urandom; cb[k] = $urandom;
        wait_res(k, oe_cnt);
        chk({nm, " oe cycles"}, 64'(oe_cnt), 64'(settle[k]));
        chk({nm, " oe off in resp"}, 64'(oe[k]), 64'd0);
        chk({nm, " res_data"}, rd[k], ed);
        chk({nm, " res_div0"}, 64'(dz[k]), 64'(edz));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk({nm, " res_data hold"}, rd[k], ed);
        handshake(k, nm);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int oe_cnt;
        logic [3:0]  op;
        logic [31:0] a, b;
        settle[0] = 1; settle[1] = 3;
        mask[0] = 16'hFFFF; mask[1] = 16'h000F;
        for (int k = 0; k < 2; k++) begin
            cv[k] = 0; rr[k] = 0; cop[k] = 0; ca[k] = 0; cb[k] = 0; exp_cnt[k] = 0;
        end
        tv[0] = '{0, 4'd0, 32'd5,          32'd7,          64'h0000_0000_0000_000C, 1'b0};
        tv[1] = '{0, 4'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 1'b0};
        tv[2] = '{0, 4'd1, 32'd3,          32'd7,          64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        tv[3] = '{0, 4'd5, 32'd100,        32'd0,          64'd0,                   1'b1};
        tv[4] = '{0, 4'd5, 32'd100,        32'd7,          64'd14,                  1'b0};
        tv[5] = '{1, 4'd6, 32'hF0F0_F0F0,  32'hFFFF_0000,  64'h0000_0000_0F0F_F0F0, 1'b0};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset alu_oe", 64'(oe[k]), 64'd0);
            chk("reset res_valid", 64'(rv[k]), 64'd0);
            chk("reset busy", 64'(bsy[k]), 64'd0);
            chk("reset op_count", 64'(oc[k]), 64'd0);
            chk("reset res_data", rd[k], 64'd0);
            chk("reset alu_a", 64'(aa[k]), 64'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            do_op(tv[i].k, tv[i].op, tv[i].a, tv[i].b, tv[i].d, tv[i].dz, $sformatf("vec%0d", i));

        // Backpressure with a pending command, then back-to-back acceptance.
        @(negedge clk);
        cv[0] = 1; cop[0] = 4'd0; ca[0] = 32'd10; cb[0] = 32'd20; rr[0] = 0;
        @(posedge clk); #1;
        cop[0] = 4'd1; ca[0] = 32'd9; cb[0] = 32'd4;
        wait_res(0, oe_cnt);
        for (int i = 0; i < 5; i++) begin
            chk("bp res_data", rd[0], 64'd30);
            chk("bp cmd_ready", 64'(crdy[0]), 64'd0);
            chk("bp op_count", 64'(oc[0]), 64'(exp_cnt[0]));
            chk("bp alu_a held", 64'(aa[0]), 64'd10);
            @(negedge clk);
        end
        rr[0] = 1; #1;
        chk("bp cmd_ready comb", 64'(crdy[0]), 64'd1);
        @(posedge clk); #1;
        rr[0] = 0; cv[0] = 0;
        exp_cnt[0] = (exp_cnt[0] + 16'd1) & mask[0];
        @(negedge clk);
        chk("b2b drive", 64'(oe[0]), 64'd1);
        chk("b2b alu_a", 64'(aa[0]), 64'd9);
        chk("b2b op_count", 64'(oc[0]), 64'(exp_cnt[0]));
        wait_res(0, oe_cnt);
        chk("b2b res_data", rd[0], 64'd5);
        handshake(0, "b2b");

        // Randomized ops against the ALU model.
        for (int i = 0; i < 40; i++) begin
            int k = int'($urandom_range(0, 1));
            op = 4'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            do_op(k, op, a, b, alu_f(op, a, b), (op == 4'd5) && (b == 0), $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of DRIVE.
        @(negedge clk);
        cv[1] = 1; cop[1] = 4'd0; ca[1] = 32'd1; cb[1] = 32'd2;
        @(posedge clk); #1;
        cv[1] = 0;
        @(negedge clk);
        chk("pre-reset drive", 64'(oe[1]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst alu_oe", 64'(oe[1]), 64'd0);
        chk("async rst busy", 64'(bsy[1]), 64'd0);
        chk("async rst res_valid", 64'(rv[1]), 64'd0);
        chk("async rst op_count0", 64'(oc[0]), 64'd0);
        chk("async rst op_count1", 64'(oc[1]), 64'd0);
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1, 4'd0, 32'd40, 32'd2, 64'd42, 1'b0, "post-reset");

        // Counter wrap on the 4-bit instance.
        while (exp_cnt[1] != 16'd15)
            do_op(1, 4'd15, 32'd7, 32'd0, 64'd7, 1'b0, "fill");
        chk("pre-wrap op_count", 64'(oc[1]), 64'd15);
        do_op(1, 4'd0, 32'd1, 32'd1, 64'd2, 1'b0, "wrap");
        chk("wrap op_count zero", 64'(oc[1]), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
